// File: rtl/mobo_mem_pkg.sv
// Shared encodings for the motherboard bus: CPU control codes, status codes,
// and the controller's internal state/op types. The FSM state values equal the
// status codes, so the status output is simply the registered state.
package mobo_mem_pkg;

  // Control codes driven by the CPU on mobo_ctrl
  localparam int CTRL_NONE  = 0;
  localparam int CTRL_READ  = 1;
  localparam int CTRL_WRITE = 2;

  // Status codes returned on mobo_stat
  localparam int STAT_IDLE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_DONE = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

endpackage

// File: rtl/mobo_mem_ram.sv
// Single-port word-addressed synchronous RAM with a registered read port.
// Read data appears one cycle after the address; read-before-write on a shared address.
// Contents are not reset.
module mobo_ram #(
  parameter int word_width = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [word_width-1:0] wdata,
  output logic [word_width-1:0] rdata
);

  logic [word_width-1:0] mem [DEPTH];

  // Write on request; always register the addressed word for reading
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mobo_mem.sv
// Motherboard memory controller: accepts one READ/WRITE at a time via a
// four-phase status handshake, spends LATENCY cycles in BUSY, then reports
// DONE (or ERR for an out-of-range address) until the CPU returns to NONE.
module mobo_mem
  import mobo_mem_pkg::*;
#(
  parameter int word_width = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  output logic [word_width-1:0] mobo_stat,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                state;
  op_e                   op_q;
  logic [CW-1:0]         cnt;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] data_q;

  logic                  cmd_read;
  logic                  cmd_write;
  logic                  cmd_none;
  logic                  last;
  logic                  in_range;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [word_width-1:0] ram_rdata;

  assign cmd_read  = (mobo_ctrl == word_width'(CTRL_READ));
  assign cmd_write = (mobo_ctrl == word_width'(CTRL_WRITE));
  assign cmd_none  = (mobo_ctrl == word_width'(CTRL_NONE));
  assign last      = (cnt == '0);

  // Full-width compare so high address bits cannot alias into the array
  assign in_range  = (addr_q < word_width'(DEPTH));

  // The RAM is addressed from addr_in while IDLE so the registered read is
  // already under way on the accept edge; this keeps data_out aligned with
  // DONE even when LATENCY is 1. While BUSY the latched address is used.
  assign ram_addr  = (state == ST_IDLE) ? addr_in[AW-1:0] : addr_q[AW-1:0];

  // Write only on the completion edge; a reset on that edge drops the write
  assign ram_we    = (state == ST_BUSY) && last && (op_q == OP_WRITE) && in_range && !rst;

  assign mobo_stat = word_width'(state);

  mobo_ram #(
    .word_width (word_width),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // Handshake FSM: accept, count latency, complete, wait for release
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_NONE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_read || cmd_write) begin
            op_q   <= cmd_read ? OP_READ : OP_WRITE;
            addr_q <= addr_in;
            data_q <= data_in;
            cnt    <= CW'(LATENCY - 1);
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!last) begin
            cnt <= cnt - 1'b1;
          end else if (!in_range) begin
            state <= ST_ERR;
          end else begin
            if (op_q == OP_READ) begin
              data_out <= ram_rdata;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          if (cmd_none) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mobo_mem.sv
// Self-checking bench for mobo_mem: one LATENCY=2 instance and one LATENCY=1
// instance, each with its own bus. Expected results come from a reference
// RAM model and are queued at stimulus time, then popped on DONE/ERR.
module tb_mobo_mem;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle count, used for access-period checks
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst0, rst1;
  logic [W-1:0] ctrl0, ctrl1, addr0, addr1, wd0, wd1;
  logic [W-1:0] stat0, stat1, dout0, dout1;

  mobo_mem #(.word_width(W), .DEPTH(256), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst0),
    .mobo_ctrl (ctrl0),
    .mobo_stat (stat0),
    .addr_in   (addr0),
    .data_in   (wd0),
    .data_out  (dout0)
  );

  mobo_mem #(.word_width(W), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .mobo_ctrl (ctrl1),
    .mobo_stat (stat1),
    .addr_in   (addr1),
    .data_in   (wd1),
    .data_out  (dout1)
  );

  typedef struct packed {
    logic [W-1:0] stat;
    logic [W-1:0] dout;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] mdl0 [256];
  logic [W-1:0] mdl1 [256];
  logic [W-1:0] last0, last1;
  int           total  = 0;
  int           passed = 0;
  int           last_drive = 0;

  // One complete handshake on the selected instance: queue the expectation,
  // drive the command, count BUSY cycles, compare on DONE/ERR, optionally hold
  // the command for extra cycles, then release and confirm IDLE.
  task automatic access(input bit which, input int op, input logic [W-1:0] a,
                        input logic [W-1:0] d, input int hold, input bit chg);
    exp_t         e;
    logic [W-1:0] lastv;
    logic [W-1:0] st;
    int           busy;
    int           k;
    int           lat;
    bit           fin;
    lat   = which ? 1 : 2;
    lastv = which ? last1 : last0;
    if (a >= 256) begin
      e.stat = 3;
      e.dout = lastv;
    end else if (op == 2) begin
      if (which) mdl1[a[7:0]] = d; else mdl0[a[7:0]] = d;
      e.stat = 2;
      e.dout = lastv;
    end else begin
      e.stat = 2;
      e.dout = which ? mdl1[a[7:0]] : mdl0[a[7:0]];
      if (which) last1 = e.dout; else last0 = e.dout;
    end
    sbq.push_back(e);

    st = which ? stat1 : stat0;
    total++;
    if (st !== 0) $display("FAIL idle_before_cmd: stat=%0d required 0", st);
    else passed++;

    if (which) begin ctrl1 = op; addr1 = a; wd1 = d; end
    else       begin ctrl0 = op; addr0 = a; wd0 = d; end
    last_drive = cyc;

    busy = 0;
    fin  = 0;
    k    = 0;
    while (!fin && k < 20) begin
      @(negedge clk);
      st = which ? stat1 : stat0;
      if (st === 1) begin
        busy++;
        if (chg) begin
          if (which) addr1 = 5; else addr0 = 5;
        end
      end else begin
        fin = 1;
      end
      k++;
    end
    e = sbq.pop_front();
    total++;
    if (!fin) $display("FAIL completion_timeout: no DONE/ERR within 20 cycles, stat=%0d", st);
    else passed++;

    total++;
    if (st !== e.stat) $display("FAIL final_stat: addr=%0d stat=%0d required %0d", a, st, e.stat);
    else passed++;
    total++;
    if ((which ? dout1 : dout0) !== e.dout)
      $display("FAIL data_out: addr=%0d got %0h required %0h", a, which ? dout1 : dout0, e.dout);
    else passed++;
    total++;
    if (busy != lat) $display("FAIL busy_cycles: addr=%0d got %0d required %0d", a, busy, lat);
    else passed++;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      st = which ? stat1 : stat0;
      total++;
      if (st !== e.stat || (which ? dout1 : dout0) !== e.dout)
        $display("FAIL held_ctrl: cycle %0d stat=%0d dout=%0h required %0d/%0h",
                 h, st, which ? dout1 : dout0, e.stat, e.dout);
      else passed++;
    end

    if (which) ctrl1 = 0; else ctrl0 = 0;
    @(negedge clk);
    st = which ? stat1 : stat0;
    total++;
    if (st !== 0) $display("FAIL release_idle: stat=%0d required 0", st);
    else passed++;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1;
    ctrl0 = 0; ctrl1 = 0; addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 0; rst1 = 0;
    @(negedge clk);
    last0 = 0; last1 = 0;
    total++;
    if (stat0 !== 0) $display("FAIL reset_stat0: got %0d required 0", stat0); else passed++;
    total++;
    if (dout0 !== 0) $display("FAIL reset_dout0: got %0h required 0", dout0); else passed++;
    total++;
    if (stat1 !== 0) $display("FAIL reset_stat1: got %0d required 0", stat1); else passed++;
    total++;
    if (dout1 !== 0) $display("FAIL reset_dout1: got %0h required 0", dout1); else passed++;
  endtask

  task automatic test_write_read();
    access(0, 2, 3, 5, 0, 0);
    access(0, 1, 3, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    access(0, 1, 256, 0, 0, 0);
    access(0, 2, 32'h8000_0003, 99, 0, 0);
    access(0, 1, 3, 0, 0, 0);
  endtask

  task automatic test_held_ctrl();
    access(0, 2, 5, 77, 0, 0);
    // addr_in moves to 5 during BUSY; the read must still return addr 3
    access(0, 1, 3, 0, 4, 1);
  endtask

  task automatic test_mid_reset();
    access(0, 2, 7, 11, 0, 0);
    ctrl0 = 2; addr0 = 7; wd0 = 9;
    @(negedge clk);
    total++;
    if (stat0 !== 1) $display("FAIL mid_reset_busy1: stat=%0d required 1", stat0); else passed++;
    @(negedge clk);
    total++;
    if (stat0 !== 1) $display("FAIL mid_reset_busy2: stat=%0d required 1", stat0); else passed++;
    rst0 = 1; ctrl0 = 0;
    @(negedge clk);
    rst0 = 0;
    last0 = 0;
    total++;
    if (stat0 !== 0) $display("FAIL mid_reset_idle: stat=%0d required 0", stat0); else passed++;
    total++;
    if (dout0 !== 0) $display("FAIL mid_reset_dout: got %0h required 0", dout0); else passed++;
    @(negedge clk);
    // The dropped write of 9 must not have landed; 11 is still there
    access(0, 1, 7, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < 2; r++) begin
        access(1, (r == 0) ? 2 : 1, i, i * 7 + 3, 0, 0);
        if (prev >= 0) begin
          total++;
          if (last_drive - prev != 3)
            $display("FAIL b2b_period: addr=%0d period=%0d required 3", i, last_drive - prev);
          else passed++;
        end
        prev = last_drive;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_held_ctrl();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
